dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Memory-stage initiator that turns CPU load/store requests into handshaked transactions on a variable-latency data-memory port.
- Generates word-aligned addresses, byte enables and lane-replicated store data.
- Extracts and zero/sign-extends load data, and detects address/bus faults.
- Asserts busy to stall the pipeline while a transaction is outstanding.

Parameters:
ADDR_LO, 32'h0000_0000, lowest legal data address (inclusive)
ADDR_HI, 32'h0000_3FFF, highest legal data address (inclusive)
TIMEOUT, 64, maximum cycles spent in REQ+WAIT before a bus error is raised (8-bit counter)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline presents a memory request
req_ready  out  1  controller can accept a request
req_we  in  1  1=store, 0=load
req_width  in  2  00 word, 01 half, 10 byte, 11 illegal
req_sign  in  1  load sign-extend (1) or zero-extend (0)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_pc  in  32  PC of the issuing instruction
mem_valid  out  1  request valid toward memory
mem_ready  in  1  memory accepts request
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  raw read word
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load result; 0 for stores
busy  out  1  stall request
exc_valid  out  1  one-cycle fault pulse
exc_code  out  5  4 AdEL, 5 AdES, 7 DBE
exc_badaddr  out  32  faulting byte address
exc_pc  out  32  PC of the faulting request

Behaviour:
- States: IDLE, REQ, WAIT, DONE, FAULT. Reset (reset=0) forces IDLE immediately, without waiting for a clock edge.
- Reset values: all outputs 0 except req_ready=1. Counter=0.
- Outputs are registered or decoded from state; no combinational path from req_* to mem_*.
- IDLE:
  - req_ready=1 and busy=0.
  - On req_valid, latch all req_* fields.
  - Fault if any of: width=11; half with addr[0]!=0; word with addr[1:0]!=0; addr<ADDR_LO; addr>ADDR_HI.
  - On fault, go to FAULT; otherwise go to REQ.
- REQ:
  - mem_valid=1, with mem_* stable until mem_ready=1.
  - On handshake: a store goes to DONE; a load goes to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - On mem_rvalid=1, select the lane: word uses the whole word; half uses addr[1]; byte uses addr[1:0].
  - Extend per req_sign, register the result into rsp_rdata, then go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - rsp_rdata holds its value until the next completion.
- FAULT:
  - exc_valid=1 for one cycle, with exc_code, exc_badaddr and exc_pc driven; then go to IDLE.
  - exc_code: load fault=4, store fault=5.
  - No memory transaction is issued.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears on leaving them.
  - On reaching TIMEOUT-1 without completion: mem_valid drops, go to FAULT with exc_code=7.
  - A late mem_rvalid arriving in IDLE is ignored.
- Byte enables:
  - Word: 1111.
  - Half: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - Byte: 0001<<addr[1:0].
  - mem_be is only meaningful with mem_we=1 and is driven to 1111 for loads.
- Store data:
  - Word: as is.
  - Half: {wd[15:0],wd[15:0]}.
  - Byte: {4{wd[7:0]}}.
- busy=1 in every state except IDLE. req_ready=!busy.
- Back-to-back requests: the earliest next accept is the cycle after DONE/FAULT, i.e. minimum occupancy 3 cycles for a store and 4 for a load.
- Reset mid-operation: mem_valid deasserts asynchronously, the in-flight transaction is abandoned, and no rsp_valid or exc_valid is produced.

Test Plan:
- Store half 0xABCD to addr 0x0000_0006 with mem_ready=1 immediately → mem_be=1100, mem_addr=0x0000_0004, mem_wdata=0xABCD_ABCD, rsp_valid 2 cycles after accept, busy high for 2 cycles.
- Load byte signed from 0x0000_0013, mem_rdata=0x80FF_0000, rvalid 3 cycles after handshake → rsp_rdata=0xFFFF_FF80; same load unsigned → 0x0000_0080.
- Load word from 0x0000_0102 → exc_valid one cycle, exc_code=4, exc_badaddr=0x0000_0102, exc_pc=req_pc, no mem_valid. Store byte to 0x0000_4000 → exc_code=5.
- mem_ready held low for 63 cycles → exc_code=7, mem_valid drops, IDLE. A subsequent stray mem_rvalid produces no rsp_valid.
- Assert reset low while in WAIT → busy=0 and mem_valid=0 without a clock edge, no rsp_valid. The next request completes normally.
- Two back-to-back word loads with 0-latency memory → second request accepted the cycle after the first rsp_valid, both results correct.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns pipeline load/store requests into
// handshaked memory transactions, with alignment/range checks, load-lane
// extraction and a bus-error timeout.
module dm_access_ctrl #(
   parameter logic [31:0] ADDR_LO = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI = 32'h0000_3FFF,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   // pipeline request side
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_width,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   // memory port
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   // completion / fault
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        busy,
   output logic        exc_valid,
   output logic [4:0]  exc_code,
   output logic [31:0] exc_badaddr,
   output logic [31:0] exc_pc
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StFault} state_t;

   localparam logic [31:0] AddrSpan = ADDR_HI - ADDR_LO;
   // Fault on the edge where the counter would reach TIMEOUT-1.
   localparam logic [7:0]  CntLast  = 8'(TIMEOUT - 2);

   localparam logic [4:0] ExcAdEL = 5'd4;
   localparam logic [4:0] ExcAdES = 5'd5;
   localparam logic [4:0] ExcDbe  = 5'd7;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        we_q;
   logic [1:0]  width_q;
   logic        sign_q;
   logic [31:0] addr_q;
   logic [31:0] pc_q;

   logic        req_fault;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [15:0] lane_h;
   logic [7:0]  lane_b;
   logic [31:0] load_ext;

   // Request decode: fault detection, byte enables and lane-replicated data
   always_comb begin
      req_fault  = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = req_wdata;
      case (req_width)
         2'b00: req_fault = |req_addr[1:0];
         2'b01: begin
            req_fault  = req_addr[0];
            be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {req_wdata[15:0], req_wdata[15:0]};
         end
         2'b10: begin
            be_calc    = 4'b0001 << req_addr[1:0];
            wdata_calc = {4{req_wdata[7:0]}};
         end
         default: req_fault = 1'b1;
      endcase
      // Offsetting by ADDR_LO makes addresses below the window wrap to a huge
      // value, so one unsigned compare covers both range limits.
      if ((req_addr - ADDR_LO) > AddrSpan) begin
         req_fault = 1'b1;
      end
      if (!req_we) begin
         be_calc = 4'b1111;
      end
   end

   // Load lane selection and zero/sign extension from the latched request
   always_comb begin
      lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      case (width_q)
         2'b00:   load_ext = mem_rdata;
         2'b01:   load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
         default: load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign req_ready = (state_q == StIdle);

   // Control FSM with registered memory, response and exception outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         we_q        <= 1'b0;
         width_q     <= 2'b00;
         sign_q      <= 1'b0;
         addr_q      <= 32'd0;
         pc_q        <= 32'd0;
         mem_valid   <= 1'b0;
         mem_we      <= 1'b0;
         mem_be      <= 4'b0000;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'd0;
         exc_valid   <= 1'b0;
         exc_code    <= 5'd0;
         exc_badaddr <= 32'd0;
         exc_pc      <= 32'd0;
      end else begin
         rsp_valid <= 1'b0;
         exc_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  width_q <= req_width;
                  sign_q  <= req_sign;
                  addr_q  <= req_addr;
                  pc_q    <= req_pc;
                  cnt_q   <= 8'd0;
                  if (req_fault) begin
                     state_q     <= StFault;
                     exc_valid   <= 1'b1;
                     exc_code    <= req_we ? ExcAdES : ExcAdEL;
                     exc_badaddr <= req_addr;
                     exc_pc      <= req_pc;
                  end else begin
                     state_q   <= StReq;
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_be    <= be_calc;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= wdata_calc;
                  end
               end
            end
            StReq: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (we_q) begin
                     state_q   <= StDone;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     cnt_q     <= 8'd0;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= cnt_q + 8'd1;
                  end
               end else if (cnt_q == CntLast) begin
                  mem_valid   <= 1'b0;
                  state_q     <= StFault;
                  exc_valid   <= 1'b1;
                  exc_code    <= ExcDbe;
                  exc_badaddr <= addr_q;
                  exc_pc      <= pc_q;
                  cnt_q       <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StWait: begin
               if (mem_rvalid) begin
                  state_q   <= StDone;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= load_ext;
                  cnt_q     <= 8'd0;
               end else if (cnt_q == CntLast) begin
                  state_q     <= StFault;
                  exc_valid   <= 1'b1;
                  exc_code    <= ExcDbe;
                  exc_badaddr <= addr_q;
                  exc_pc      <= pc_q;
                  cnt_q       <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StDone:  state_q <= StIdle;
            StFault: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a vector table for single transactions
// plus hand-written timing, timeout, reset and back-to-back sequences.
module tb_dm_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_width;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_badaddr;
   logic [31:0] exc_pc;

   int n_checks = 0;
   int n_fail   = 0;

   dm_access_ctrl #(
      .ADDR_LO (32'h0000_0000),
      .ADDR_HI (32'h0000_3FFF),
      .TIMEOUT (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_width   (req_width),
      .req_sign    (req_sign),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_pc      (req_pc),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .exc_valid   (exc_valid),
      .exc_code    (exc_code),
      .exc_badaddr (exc_badaddr),
      .exc_pc      (exc_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  width;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
      logic [4:0]  code;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rsp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [1:0] width, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic fault,
                               input logic [4:0] code, input logic [3:0] be,
                               input logic [31:0] maddr, input logic [31:0] mwdata,
                               input logic [31:0] rsp);
      vec_t v;
      v.we = we; v.width = width; v.sign = sign; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.fault = fault; v.code = code; v.be = be; v.maddr = maddr;
      v.mwdata = mwdata; v.rsp = rsp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [1:0] width, input logic sign,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] pc);
      req_valid = 1'b1;
      req_we    = we;
      req_width = width;
      req_sign  = sign;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = pc;
   endtask

   // One transaction from the table: memory accepts at once, read data in the
   // first WAIT cycle.
   task automatic run_vec(input vec_t v, input int idx);
      int          lat;
      bit          seen;
      logic [31:0] pc;
      pc = 32'h0000_1000 + 32'(idx) * 4;
      chk($sformatf("v%0d req_ready idle", idx), req_ready, 1);
      drive_req(v.we, v.width, v.sign, v.addr, v.wdata, pc);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      step();
      req_valid = 1'b0;
      if (v.fault) begin
         chk($sformatf("v%0d exc_valid", idx), exc_valid, 1);
         chk($sformatf("v%0d exc_code", idx), exc_code, v.code);
         chk($sformatf("v%0d exc_badaddr", idx), exc_badaddr, v.addr);
         chk($sformatf("v%0d exc_pc", idx), exc_pc, pc);
         chk($sformatf("v%0d mem_valid on fault", idx), mem_valid, 0);
         chk($sformatf("v%0d busy on fault", idx), busy, 1);
         step();
         chk($sformatf("v%0d exc_valid pulse", idx), exc_valid, 0);
         chk($sformatf("v%0d busy after fault", idx), busy, 0);
      end else begin
         chk($sformatf("v%0d mem_valid", idx), mem_valid, 1);
         chk($sformatf("v%0d mem_we", idx), mem_we, v.we);
         chk($sformatf("v%0d mem_addr", idx), mem_addr, v.maddr);
         chk($sformatf("v%0d mem_be", idx), mem_be, v.be);
         chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwdata);
         seen = 1'b0;
         lat  = 0;
         while (!seen && lat < 10) begin
            step();
            lat++;
            if (rsp_valid) seen = 1'b1;
         end
         chk($sformatf("v%0d rsp seen", idx), seen, 1);
         chk($sformatf("v%0d rsp latency", idx), lat, v.we ? 1 : 2);
         chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rsp);
         step();
         chk($sformatf("v%0d rsp pulse", idx), rsp_valid, 0);
         chk($sformatf("v%0d rsp_rdata hold", idx), rsp_rdata, v.rsp);
         chk($sformatf("v%0d req_ready after", idx), req_ready, 1);
      end
      mem_rvalid = 1'b0;
   endtask

   // Load byte from 0x13 with read data three cycles after the handshake
   task automatic slow_byte_load(input logic sign, input logic [31:0] exp);
      drive_req(1'b0, 2'b10, sign, 32'h0000_0013, 32'd0, 32'h0000_2000);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h80FF_0000;
      step();
      req_valid = 1'b0;
      chk("slow mem_valid", mem_valid, 1);
      chk("slow mem_addr", mem_addr, 32'h0000_0010);
      step();
      chk("slow mem_valid after hs", mem_valid, 0);
      chk("slow busy in wait", busy, 1);
      step();
      chk("slow no early rsp 1", rsp_valid, 0);
      step();
      chk("slow no early rsp 2", rsp_valid, 0);
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      chk("slow rsp_valid", rsp_valid, 1);
      chk("slow rsp_rdata", rsp_rdata, exp);
      step();
      chk("slow rsp pulse", rsp_valid, 0);
      chk("slow rsp_rdata hold", rsp_rdata, exp);
      chk("slow idle", req_ready, 1);
   endtask

   // Transaction that never completes; expects a bus error after 63 cycles
   task automatic timeout_case(input logic we, input logic [31:0] addr, input logic ready,
                               input int exp_mv, input string tag);
      int cyc;
      int n_mv;
      bit got_exc;
      drive_req(we, 2'b00, 1'b0, addr, 32'h0000_0077, 32'h0000_3000);
      mem_ready  = ready;
      mem_rvalid = 1'b0;
      step();
      req_valid = 1'b0;
      cyc     = 0;
      n_mv    = 0;
      got_exc = 1'b0;
      while (!got_exc && cyc < 200) begin
         if (mem_valid) n_mv++;
         step();
         cyc++;
         if (exc_valid) got_exc = 1'b1;
      end
      chk({tag, " exc seen"}, got_exc, 1);
      chk({tag, " cycles to exc"}, cyc, 63);
      chk({tag, " mem_valid cycles"}, n_mv, exp_mv);
      chk({tag, " exc_code"}, exc_code, 5'd7);
      chk({tag, " exc_badaddr"}, exc_badaddr, addr);
      chk({tag, " exc_pc"}, exc_pc, 32'h0000_3000);
      chk({tag, " mem_valid dropped"}, mem_valid, 0);
      step();
      chk({tag, " idle after"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0] busy_pat;
      logic [3:0] rsp_pat;
      logic [8:0] b2b_pat;
      int         stray;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_width  = 2'b00;
      req_sign   = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_pc     = 32'd0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;

      //          we    wid    sg    addr           wdata          rdata          flt  code be       maddr          mwdata         rsp
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 4'b1111, 32'h0000_0100, 32'h1234_5678, 32'h0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 32'h0, 1'b0, 5'd0, 4'b1100, 32'h0000_0004, 32'hABCD_ABCD, 32'h0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0008, 32'hFFFF_1234, 32'h0, 1'b0, 5'd0, 4'b0011, 32'h0000_0008, 32'h1234_1234, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0021, 32'h0000_005A, 32'h0, 1'b0, 5'd0, 4'b0010, 32'h0000_0020, 32'h5A5A_5A5A, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0023, 32'h0000_00C3, 32'h0, 1'b0, 5'd0, 4'b1000, 32'h0000_0020, 32'hC3C3_C3C3, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd0, 4'b1111, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1'b0, 5'd0, 4'b1111, 32'h0000_0200, 32'h0, 32'hFFFF_8001));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1'b0, 5'd0, 4'b1111, 32'h0000_0200, 32'h0, 32'h0000_8001));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 1'b0, 5'd0, 4'b1111, 32'h0000_0200, 32'h0, 32'h0000_7FFF));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0, 32'h1234_A5F0, 1'b0, 5'd0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0000_00A5));
      vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0000_0011, 32'h0, 32'h1234_A5F0, 1'b0, 5'd0, 4'b1111, 32'h0000_0010, 32'h0, 32'hFFFF_FFA5));
      vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0000_0012, 32'h0, 32'h1234_A5F0, 1'b0, 5'd0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0000_0034));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 4'b1111, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_3FFF, 32'h0, 32'hAB00_0000, 1'b0, 5'd0, 4'b1111, 32'h0000_3FFC, 32'h0, 32'h0000_00AB));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 5'd4, 4'b0, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 5'd5, 4'b0, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 5'd4, 4'b0, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 5'd5, 4'b0, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 5'd4, 4'b0, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 5'd4, 4'b0, 32'h0, 32'h0, 32'h0));

      // Reset values, visible without a clock edge
      #1;
      chk("reset req_ready", req_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset mem_valid", mem_valid, 0);
      chk("reset mem_be", mem_be, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset exc_valid", exc_valid, 0);
      chk("reset exc_code", exc_code, 0);
      step();
      step();
      reset = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Store half: busy for REQ and DONE, response in the second cycle
      drive_req(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 32'h0000_0400);
      mem_ready = 1'b1;
      busy_pat  = 4'b0;
      rsp_pat   = 4'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         req_valid  = 1'b0;
         busy_pat[k] = busy;
         rsp_pat[k]  = rsp_valid;
      end
      chk("store half busy pattern", busy_pat, 4'b0011);
      chk("store half rsp pattern", rsp_pat, 4'b0010);

      slow_byte_load(1'b1, 32'hFFFF_FF80);
      slow_byte_load(1'b0, 32'h0000_0080);

      // Read data while still in REQ must be ignored
      drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 32'h0000_0500);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      step();
      req_valid = 1'b0;
      step();
      chk("req-rvalid no rsp", rsp_valid, 0);
      chk("req-rvalid mem_valid held", mem_valid, 1);
      chk("req-rvalid mem_addr stable", mem_addr, 32'h0000_0040);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b0;
      step();
      chk("req-rvalid mem_valid after hs", mem_valid, 0);
      chk("req-rvalid still no rsp", rsp_valid, 0);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h2222_2222;
      step();
      mem_rvalid = 1'b0;
      chk("req-rvalid rsp_valid", rsp_valid, 1);
      chk("req-rvalid rsp_rdata", rsp_rdata, 32'h2222_2222);
      step();

      timeout_case(1'b1, 32'h0000_0010, 1'b0, 63, "tmo req");
      // Stray read data after the timeout must not produce a response
      stray = 0;
      mem_rvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (rsp_valid || exc_valid) stray++;
      end
      mem_rvalid = 1'b0;
      chk("stray rvalid ignored", stray, 0);
      timeout_case(1'b0, 32'h0000_0014, 1'b1, 1, "tmo wait");

      // Reset while in REQ: mem_valid drops asynchronously
      drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'd0, 32'h0000_0600);
      mem_ready = 1'b0;
      step();
      req_valid = 1'b0;
      chk("rst-req mem_valid before", mem_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst-req mem_valid async", mem_valid, 0);
      chk("rst-req busy async", busy, 0);
      chk("rst-req req_ready async", req_ready, 1);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      stray = 0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (rsp_valid || exc_valid) stray++;
      end
      reset = 1'b1;
      mem_rvalid = 1'b0;
      step();
      if (rsp_valid || exc_valid) stray++;
      chk("rst-req no completion", stray, 0);

      // Reset while in WAIT: busy drops asynchronously, no response
      drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0034, 32'd0, 32'h0000_0700);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      chk("rst-wait busy before", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst-wait busy async", busy, 0);
      chk("rst-wait mem_valid", mem_valid, 0);
      chk("rst-wait rsp_rdata cleared", rsp_rdata, 0);
      mem_rvalid = 1'b1;
      stray = 0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (rsp_valid || exc_valid) stray++;
      end
      reset = 1'b1;
      mem_rvalid = 1'b0;
      step();
      if (rsp_valid || exc_valid) stray++;
      chk("rst-wait no completion", stray, 0);
      run_vec(mk(1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 1'b0, 5'd0,
                 4'b1111, 32'h0000_0030, 32'h0, 32'h0BAD_F00D), 100);

      // Back-to-back word loads with zero-latency memory
      drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0080, 32'd0, 32'h0000_0800);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA1A2_A3A4;
      b2b_pat    = 9'b0;
      for (int k = 0; k <= 8; k++) begin
         step();
         b2b_pat[k] = rsp_valid;
         if (k == 0) begin
            req_addr = 32'h0000_0084;
            req_pc   = 32'h0000_0804;
         end
         if (k == 2) begin
            chk("b2b first rsp_rdata", rsp_rdata, 32'hA1A2_A3A4);
            chk("b2b not ready in DONE", req_ready, 0);
            mem_rdata = 32'hB1B2_B3B4;
         end
         if (k == 3) chk("b2b ready after DONE", req_ready, 1);
         if (k == 4) begin
            chk("b2b second accepted", mem_valid, 1);
            chk("b2b second mem_addr", mem_addr, 32'h0000_0084);
            req_valid = 1'b0;
         end
         if (k == 6) chk("b2b second rsp_rdata", rsp_rdata, 32'hB1B2_B3B4);
      end
      mem_rvalid = 1'b0;
      chk("b2b rsp pattern", b2b_pat, 9'b0_0100_0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
